x_calculator: RTL and testbench
===============================

// Module: x_calculator
// PURPOSE
//   X-coordinate update stage of one CORDIC micro-rotation (vectoring unit).
//   Computes x(i+1) = x(i) - m*sigma*(y(i)>>i) for circular, linear and hyperbolic
//   coordinate systems. The shifted y term arrives pre-computed on y_shift.
//   Sits beside the Y/Z calculators in each CORDIC iteration; the result is registered.
// PARAMETERS
//   WIDTH      32  data width of x, y, angle, y_shift, x_out (two's complement)
//   VECTORING  1   1: sigma from sign of y (vectoring); 0: sigma from sign of angle (rotation)
// PORTS
//   clock      in   1      rising-edge clock
//   reset_n    in   1      asynchronous active-low reset
//   in_valid   in   1      operands valid this cycle; capture enable
//   x          in   WIDTH  current x(i), signed
//   y          in   WIDTH  current y(i), signed; sign used when VECTORING=1
//   angle      in   WIDTH  current z(i) residual angle, signed; sign used when VECTORING=0
//   mode       in   2      `CIRCULAR, `LINEAR, `HYPERBOLIC (CONSTANTS.v); 2'b11 reserved
//   y_shift    in   WIDTH  y(i) arithmetically shifted by the iteration index, signed
//   x_out      out  WIDTH  registered x(i+1)
//   out_valid  out  1      x_out holds a new result
// BEHAVIOUR
//   - Encodings: `CIRCULAR=2'b00, `LINEAR=2'b01, `HYPERBOLIC=2'b10.
//   - Direction: VECTORING=1: sigma=+1 if y[WIDTH-1]=1 (y<0), else -1 (y=0 -> -1).
//     VECTORING=0: sigma=+1 if angle[WIDTH-1]=0 (angle>=0), else -1.
//   - Next value (combinational, then registered):
//       CIRCULAR   : nx = (sigma>0) ? x - y_shift : x + y_shift
//       HYPERBOLIC : nx = (sigma>0) ? x + y_shift : x - y_shift
//       LINEAR     : nx = x
//       2'b11      : nx = x (pass-through, no error flag)
//   - Arithmetic: WIDTH-bit two's complement, result wraps modulo 2^WIDTH; no
//     saturation, no overflow flag. Single adder/subtractor, add/sub select decoded.
//   - Latency: 1 cycle. On rising clock with in_valid=1: x_out<=nx, out_valid<=1.
//     With in_valid=0: x_out holds previous value, out_valid<=0.
//   - Back-to-back in_valid accepted every cycle (throughput 1/clock); no backpressure.
//   - Reset: reset_n=0 immediately (asynchronously) forces x_out=0, out_valid=0,
//     regardless of clock; also mid-operation. First capture on first rising edge
//     with reset_n=1 and in_valid=1.
//   - Inputs sampled only at the clock edge; input changes between edges do not
//     affect x_out.
// TESTING
//   - VECTORING=1, CIRCULAR, x=25, y=40, y_shift=32'hCF000000, in_valid=1 -> next
//     edge x_out=32'hCF000019, out_valid=1.
//   - VECTORING=1, HYPERBOLIC, x=15, y=35, y_shift=32'h5E300000 -> x_out=32'hA1D0000F.
//   - LINEAR, x=20, y=50, angle=32'h56000000, y_shift=32'h3E0A0000 -> x_out=32'h00000014.
//   - VECTORING=1, CIRCULAR, x=25, y=32'hFFFFFFD8 (-40), y_shift=5 -> x_out=20;
//     mode=2'b11, x=7 -> x_out=7.
//   - VECTORING=0, CIRCULAR, x=25, angle=32'h10F00000, y_shift=32'hCF000000 ->
//     x_out=32'h31000019; angle=32'h9C000000 same operands -> x_out=32'hCF000019.
//   - Drive valid stream, drop reset_n between edges -> x_out=0, out_valid=0 at once;
//     in_valid=0 for 3 cycles -> x_out held, out_valid=0.

Source files
------------

// File: rtl/x_calculator.sv
// X-coordinate update for one CORDIC micro-rotation.
// Computes x(i+1) = x(i) - m*sigma*(y(i)>>i) for the circular, linear and
// hyperbolic systems, using a single shared adder/subtractor. The result is
// registered with a one-cycle latency and carries a valid flag.
module x_calculator #(
    parameter int WIDTH     = 32,
    parameter bit VECTORING = 1'b1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [WIDTH-1:0] angle,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] y_shift,
    output logic [WIDTH-1:0] x_out,
    output logic             out_valid
);

    localparam logic [1:0] MODE_CIRCULAR   = 2'b00;
    localparam logic [1:0] MODE_LINEAR     = 2'b01;
    localparam logic [1:0] MODE_HYPERBOLIC = 2'b10;

    logic signed [WIDTH-1:0] x_s;
    logic signed [WIDTH-1:0] y_shift_s;
    logic signed [WIDTH-1:0] operand;
    logic signed [WIDTH-1:0] sum;
    logic                    sigma_pos;
    logic                    do_sub;
    logic                    do_update;
    logic [WIDTH-1:0]        x_out_d;
    logic [WIDTH-1:0]        x_out_q;
    logic                    out_valid_d;
    logic                    out_valid_q;
    logic                    unused_bits;

    // Only the sign bits of y and angle steer the rotation; the magnitudes
    // arrive already folded into y_shift.
    assign unused_bits = ^{y[WIDTH-2:0], angle[WIDTH-2:0]};

    // Rotation direction, add/sub select and the shared adder.
    always_comb begin
        x_s       = signed'(x);
        y_shift_s = signed'(y_shift);
        // Vectoring drives y toward zero: rotate positive while y is negative
        // (y == 0 counts as non-negative). Rotation drives the angle to zero.
        if (VECTORING)
            sigma_pos = y[WIDTH-1];
        else
            sigma_pos = ~angle[WIDTH-1];
        // Circular subtracts for sigma=+1; hyperbolic has m=-1 so the sense flips.
        do_sub    = ((mode == MODE_CIRCULAR)   &&  sigma_pos) ||
                    ((mode == MODE_HYPERBOLIC) && !sigma_pos);
        // Linear and the reserved encoding leave x untouched.
        do_update = (mode == MODE_CIRCULAR) || (mode == MODE_HYPERBOLIC);
        operand   = do_sub ? ~y_shift_s : y_shift_s;
        sum       = x_s + operand + signed'({{(WIDTH-1){1'b0}}, do_sub});
    end

    // Next-state values: capture on in_valid, otherwise hold x and drop valid.
    always_comb begin
        x_out_d     = x_out_q;
        out_valid_d = 1'b0;
        if (in_valid) begin
            x_out_d     = do_update ? unsigned'(sum) : x;
            out_valid_d = 1'b1;
        end
    end

    // Output register with asynchronous clear.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            x_out_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            x_out_q     <= x_out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign x_out     = x_out_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_x_calculator.sv
// Directed bench for x_calculator: one instance in vectoring mode and one in
// rotation mode share the same stimulus.
module tb_x_calculator;

    localparam logic [1:0] CIRC = 2'b00;
    localparam logic [1:0] LIN  = 2'b01;
    localparam logic [1:0] HYP  = 2'b10;
    localparam logic [1:0] RSV  = 2'b11;

    logic        clock;
    logic        reset_n;
    logic        in_valid;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] angle;
    logic [1:0]  mode;
    logic [31:0] y_shift;
    logic [31:0] xo_v;
    logic        ov_v;
    logic [31:0] xo_r;
    logic        ov_r;

    int total;
    int bad;

    x_calculator #(.WIDTH(32), .VECTORING(1'b1)) dut_v (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid),
        .x(x), .y(y), .angle(angle), .mode(mode), .y_shift(y_shift),
        .x_out(xo_v), .out_valid(ov_v)
    );

    x_calculator #(.WIDTH(32), .VECTORING(1'b0)) dut_r (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid),
        .x(x), .y(y), .angle(angle), .mode(mode), .y_shift(y_shift),
        .x_out(xo_r), .out_valid(ov_r)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic iv, input logic [31:0] xi, input logic [31:0] yi,
                         input logic [31:0] ai, input logic [1:0] mi, input logic [31:0] ysi);
        @(negedge clock);
        in_valid = iv;
        x        = xi;
        y        = yi;
        angle    = ai;
        mode     = mi;
        y_shift  = ysi;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        in_valid = 1'b1;
        x        = 32'd99;
        y        = 32'd1;
        angle    = 32'd1;
        mode     = CIRC;
        y_shift  = 32'd1;
        #1;
        total++; if (xo_v !== 32'h0) begin bad++; $display("FAIL reset_xout_v got=%h want=%h", xo_v, 32'h0); end
        total++; if (ov_v !== 1'b0) begin bad++; $display("FAIL reset_valid_v got=%b want=0", ov_v); end
        total++; if (xo_r !== 32'h0) begin bad++; $display("FAIL reset_xout_r got=%h want=%h", xo_r, 32'h0); end
        step();
        total++; if (ov_v !== 1'b0 || xo_v !== 32'h0) begin bad++; $display("FAIL reset_held_edge got=%h/%b want=0/0", xo_v, ov_v); end
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_circular_vectoring();
        drive(1'b1, 32'd25, 32'd40, 32'h0, CIRC, 32'hCF000000);
        step();
        total++; if (xo_v !== 32'hCF000019) begin bad++; $display("FAIL circ_y_pos got=%h want=%h", xo_v, 32'hCF000019); end
        total++; if (ov_v !== 1'b1) begin bad++; $display("FAIL circ_valid got=%b want=1", ov_v); end
        drive(1'b1, 32'd25, 32'hFFFFFFD8, 32'h0, CIRC, 32'd5);
        step();
        total++; if (xo_v !== 32'd20) begin bad++; $display("FAIL circ_y_neg got=%h want=%h", xo_v, 32'd20); end
        drive(1'b1, 32'd10, 32'd0, 32'h0, CIRC, 32'd3);
        step();
        total++; if (xo_v !== 32'd13) begin bad++; $display("FAIL circ_y_zero got=%h want=%h", xo_v, 32'd13); end
        drive(1'b1, 32'h7FFFFFFF, 32'd1, 32'h0, CIRC, 32'd1);
        step();
        total++; if (xo_v !== 32'h80000000) begin bad++; $display("FAIL circ_wrap got=%h want=%h", xo_v, 32'h80000000); end
    endtask

    task automatic test_hyperbolic();
        drive(1'b1, 32'd15, 32'd35, 32'h0, HYP, 32'h5E300000);
        step();
        total++; if (xo_v !== 32'hA1D0000F) begin bad++; $display("FAIL hyp_y_pos got=%h want=%h", xo_v, 32'hA1D0000F); end
        drive(1'b1, 32'd15, 32'hFFFFFFFF, 32'h0, HYP, 32'h5E300000);
        step();
        total++; if (xo_v !== 32'h5E30000F) begin bad++; $display("FAIL hyp_y_neg got=%h want=%h", xo_v, 32'h5E30000F); end
    endtask

    task automatic test_linear_reserved();
        drive(1'b1, 32'd20, 32'd50, 32'h56000000, LIN, 32'h3E0A0000);
        step();
        total++; if (xo_v !== 32'h00000014) begin bad++; $display("FAIL linear_v got=%h want=%h", xo_v, 32'h14); end
        total++; if (xo_r !== 32'h00000014) begin bad++; $display("FAIL linear_r got=%h want=%h", xo_r, 32'h14); end
        drive(1'b1, 32'd7, 32'hFFFFFFD8, 32'h0, RSV, 32'd5);
        step();
        total++; if (xo_v !== 32'd7) begin bad++; $display("FAIL reserved got=%h want=%h", xo_v, 32'd7); end
        total++; if (ov_v !== 1'b1) begin bad++; $display("FAIL reserved_valid got=%b want=1", ov_v); end
    endtask

    task automatic test_rotation();
        drive(1'b1, 32'd25, 32'd40, 32'h10F00000, CIRC, 32'hCF000000);
        step();
        total++; if (xo_r !== 32'h31000019) begin bad++; $display("FAIL rot_angle_pos got=%h want=%h", xo_r, 32'h31000019); end
        drive(1'b1, 32'd25, 32'd40, 32'h9C000000, CIRC, 32'hCF000000);
        step();
        total++; if (xo_r !== 32'hCF000019) begin bad++; $display("FAIL rot_angle_neg got=%h want=%h", xo_r, 32'hCF000019); end
        drive(1'b1, 32'd10, 32'd40, 32'h0, CIRC, 32'd3);
        step();
        total++; if (xo_r !== 32'd7) begin bad++; $display("FAIL rot_angle_zero got=%h want=%h", xo_r, 32'd7); end
        drive(1'b1, 32'd10, 32'd40, 32'h0, HYP, 32'd3);
        step();
        total++; if (xo_r !== 32'd13) begin bad++; $display("FAIL rot_hyp got=%h want=%h", xo_r, 32'd13); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] xs [3];
        logic [31:0] ys [3];
        logic [31:0] ex [3];
        xs = '{32'd100, 32'd200, 32'd300};
        ys = '{32'd1,   32'd2,   32'd3};
        ex = '{32'd101, 32'd198, 32'd303};
        for (int i = 0; i < 3; i++) begin
            // i=1 uses a negative y so the direction flips between cycles.
            drive(1'b1, xs[i], (i == 1) ? 32'hFFFFFFF0 : 32'd4, 32'h0, CIRC, ys[i]);
            step();
            total++; if (xo_v !== ex[i] || ov_v !== 1'b1) begin
                bad++; $display("FAIL b2b_%0d got=%h/%b want=%h/1", i, xo_v, ov_v, ex[i]);
            end
        end
    endtask

    task automatic test_hold();
        drive(1'b1, 32'd100, 32'd1, 32'h0, CIRC, 32'd0);
        step();
        total++; if (xo_v !== 32'd100) begin bad++; $display("FAIL hold_load got=%h want=%h", xo_v, 32'd100); end
        // Input change between edges must not reach the output.
        x = 32'd777;
        #2;
        total++; if (xo_v !== 32'd100) begin bad++; $display("FAIL between_edges got=%h want=%h", xo_v, 32'd100); end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 32'd555 + i, 32'd1, 32'h0, CIRC, 32'd9);
            step();
            total++; if (xo_v !== 32'd100 || ov_v !== 1'b0) begin
                bad++; $display("FAIL hold_%0d got=%h/%b want=%h/0", i, xo_v, ov_v, 32'd100);
            end
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 32'd50, 32'd1, 32'h0, CIRC, 32'd5);
        step();
        total++; if (xo_v !== 32'd55) begin bad++; $display("FAIL mid_pre got=%h want=%h", xo_v, 32'd55); end
        #2;
        reset_n = 1'b0;
        #1;
        total++; if (xo_v !== 32'h0 || ov_v !== 1'b0) begin bad++; $display("FAIL mid_async got=%h/%b want=0/0", xo_v, ov_v); end
        total++; if (xo_r !== 32'h0 || ov_r !== 1'b0) begin bad++; $display("FAIL mid_async_r got=%h/%b want=0/0", xo_r, ov_r); end
        step();
        total++; if (xo_v !== 32'h0 || ov_v !== 1'b0) begin bad++; $display("FAIL mid_held got=%h/%b want=0/0", xo_v, ov_v); end
        @(negedge clock);
        reset_n = 1'b1;
        drive(1'b1, 32'd60, 32'd1, 32'h0, CIRC, 32'd5);
        step();
        total++; if (xo_v !== 32'd65 || ov_v !== 1'b1) begin bad++; $display("FAIL mid_recover got=%h/%b want=%h/1", xo_v, ov_v, 32'd65); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_circular_vectoring();
        test_hyperbolic();
        test_linear_reserved();
        test_rotation();
        test_back_to_back();
        test_hold();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
